mem_access_splitter: RTL and testbench

Parametrised load/store access unit between the core's data port and a narrow memory backend (on-chip RAM or cache). Accepts byte/half/word requests at any byte address, splits them into 1–3 beat-aligned backend transactions with byte enables, reassembles read data with sign/zero extension, and returns a single response. It adds three things the single-mode splitter lacks: a backend beat width of 16 or 32 bits, an optional misaligned-access trap, and a ready/valid request handshake.

---
 rtl/mem_access_splitter.sv | 189 ++++++++++++++++++
 tb/tb_mem_access_splitter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_splitter.sv
// Load/store unit front end: splits byte/half/word requests into
// beat-aligned backend accesses and reassembles the load result.
module mem_access_splitter #(
  parameter int BEAT_BYTES     = 2,
  parameter bit BYTE_SWAP      = 1'b1,
  parameter bit ALLOW_MISALIGN = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [31:0]             req_addr,
  input  logic                    req_rw,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [31:0]             req_wdata,
  output logic                    rsp_valid,
  output logic                    rsp_err,
  output logic [31:0]             rsp_rdata,
  output logic                    mem_req,
  output logic                    mem_rw,
  output logic [31:0]             mem_addr,
  output logic [BEAT_BYTES-1:0]   mem_be,
  output logic [8*BEAT_BYTES-1:0] mem_wdata,
  input  logic                    mem_ack,
  input  logic [8*BEAT_BYTES-1:0] mem_rdata
);

  localparam int BW = 8 * BEAT_BYTES;
  localparam int OB = $clog2(BEAT_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic [31:0]   addr_q;
  logic          rw_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [31:0]   wdata_q;
  logic          err_q;
  logic [1:0]    b_q;
  logic [1:0]    beats_q;
  logic [31:0]   res_q;
  logic [31:0]   rdata_q;

  logic          accept;
  logic [3:0]    in_off;
  logic [3:0]    in_n;
  logic [3:0]    in_span;
  logic [1:0]    in_beats;
  logic          in_misal;
  logic          in_err;

  logic [3:0]    off;
  logic [3:0]    n;
  logic          last;
  logic          issuing;
  logic [3:0]    lane;
  logic [3:0]    p;
  logic [3:0]    ri;
  logic [4:0]    sh;
  logic [BEAT_BYTES-1:0] beat_be;
  logic [BW-1:0] beat_wd;
  logic [31:0]   merged;

  function automatic logic [31:0] extend(
    input logic [31:0] v,
    input logic [1:0]  sz,
    input logic        u
  );
    logic [31:0] r;
    case (sz)
      2'd0:    r = {{24{!u && v[7]}}, v[7:0]};
      2'd1:    r = {{16{!u && v[15]}}, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  assign accept   = req_valid && req_ready;
  assign in_off   = 4'(req_addr[OB-1:0]);
  assign in_n     = 4'd1 << req_size;
  assign in_span  = in_off + in_n + 4'(BEAT_BYTES - 1);
  assign in_beats = 2'(in_span >> OB);
  assign in_misal = (req_size == 2'd1 && req_addr[0]) ||
                    (req_size == 2'd2 && req_addr[1:0] != 2'b00);
  assign in_err   = (req_size == 2'd3) ||
                    (!ALLOW_MISALIGN && in_misal);

  assign off  = 4'(addr_q[OB-1:0]);
  assign n    = 4'd1 << size_q;
  assign last = (b_q == beats_q - 2'd1);

  // Walk byte positions of the beat; find which request byte
  // (if any) each one carries in beat b_q.
  always_comb begin
    beat_be = '0;
    beat_wd = '0;
    merged  = res_q;
    lane    = '0;
    p       = '0;
    ri      = '0;
    sh      = '0;
    for (int k = 0; k < BEAT_BYTES; k++) begin
      lane = BYTE_SWAP ? 4'(BEAT_BYTES - 1 - k) : 4'(k);
      p    = 4'(b_q) * 4'(BEAT_BYTES) + lane;
      ri   = p - off;
      sh   = {ri[1:0], 3'b000};
      if (p >= off && ri < n) begin
        beat_be[k]         = 1'b1;
        beat_wd[8*k +: 8]  = wdata_q[sh +: 8];
        merged[sh +: 8]    = mem_rdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = in_err ? RESP : ISSUE;
      ISSUE:   if (mem_ack && last) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      rw_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      b_q     <= '0;
      beats_q <= '0;
      res_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == IDLE && req_valid) begin
        addr_q  <= req_addr;
        rw_q    <= req_rw;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        wdata_q <= req_wdata;
        err_q   <= in_err;
        b_q     <= '0;
        beats_q <= in_beats;
        res_q   <= '0;
        if (in_err) rdata_q <= '0;
      end
      if (state_q == ISSUE && mem_ack) begin
        res_q <= merged;
        b_q   <= b_q + 2'd1;
        if (last)
          rdata_q <= rw_q ? '0 : extend(merged, size_q, uns_q);
      end
    end
  end

  // Gating with reset drops every strobe combinationally.
  assign issuing   = (state_q == ISSUE) && !reset;
  assign req_ready = (state_q == IDLE) && !reset;
  assign rsp_valid = (state_q == RESP) && !reset;
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = rdata_q;

  assign mem_req   = issuing;
  assign mem_rw    = issuing && rw_q;
  assign mem_addr  = issuing ?
    {addr_q[31:OB], {OB{1'b0}}} + 32'(b_q) * 32'(BEAT_BYTES) : '0;
  assign mem_be    = issuing ? beat_be : '0;
  assign mem_wdata = issuing ? beat_wd : '0;

  // accept is the architectural handshake; state_q gates it in the ff.
  logic unused_accept;
  assign unused_accept = accept;

endmodule

// File: tb/tb_mem_access_splitter.sv
// Directed + random bench for mem_access_splitter; two instances
// (16-bit swapped beats, 32-bit unswapped beats with misalign trap).
module tb_mem_access_splitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        rv2, rv4;
  logic [31:0] raddr;
  logic        rrw;
  logic [1:0]  rsize;
  logic        runs;
  logic [31:0] rwd;
  logic        mack;
  logic [31:0] mrd;

  logic        rdy2, vld2, err2, mreq2, mrw2;
  logic [31:0] rd2, ma2;
  logic [1:0]  be2;
  logic [15:0] wd2;
  logic        rdy4, vld4, err4, mreq4, mrw4;
  logic [31:0] rd4, ma4;
  logic [3:0]  be4;
  logic [31:0] wd4;

  mem_access_splitter #(
    .BEAT_BYTES(2), .BYTE_SWAP(1'b1), .ALLOW_MISALIGN(1'b1)
  ) u2 (
    .clk(clk), .reset(reset),
    .req_valid(rv2), .req_ready(rdy2), .req_addr(raddr),
    .req_rw(rrw), .req_size(rsize), .req_unsigned(runs),
    .req_wdata(rwd), .rsp_valid(vld2), .rsp_err(err2),
    .rsp_rdata(rd2), .mem_req(mreq2), .mem_rw(mrw2),
    .mem_addr(ma2), .mem_be(be2), .mem_wdata(wd2),
    .mem_ack(mack), .mem_rdata(mrd[15:0])
  );

  mem_access_splitter #(
    .BEAT_BYTES(4), .BYTE_SWAP(1'b0), .ALLOW_MISALIGN(1'b0)
  ) u4 (
    .clk(clk), .reset(reset),
    .req_valid(rv4), .req_ready(rdy4), .req_addr(raddr),
    .req_rw(rrw), .req_size(rsize), .req_unsigned(runs),
    .req_wdata(rwd), .rsp_valid(vld4), .rsp_err(err4),
    .rsp_rdata(rd4), .mem_req(mreq4), .mem_rw(mrw4),
    .mem_addr(ma4), .mem_be(be4), .mem_wdata(wd4),
    .mem_ack(mack), .mem_rdata(mrd)
  );

  bit sel;
  logic [31:0] c_rdy, c_vld, c_err, c_rd, c_mreq, c_mrw;
  logic [31:0] c_ma, c_be, c_wd;

  always_comb begin
    if (sel) begin
      c_rdy = {31'b0, rdy4}; c_vld = {31'b0, vld4};
      c_err = {31'b0, err4}; c_rd = rd4;
      c_mreq = {31'b0, mreq4}; c_mrw = {31'b0, mrw4};
      c_ma = ma4; c_be = {28'b0, be4}; c_wd = wd4;
    end else begin
      c_rdy = {31'b0, rdy2}; c_vld = {31'b0, vld2};
      c_err = {31'b0, err2}; c_rd = rd2;
      c_mreq = {31'b0, mreq2}; c_mrw = {31'b0, mrw2};
      c_ma = ma2; c_be = {30'b0, be2}; c_wd = {16'b0, wd2};
    end
  end

  int nvec = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Backend memory image: explicit bytes override a fixed hash.
  logic [7:0] mem [logic [31:0]];

  function automatic logic [7:0] mbyte(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a[7:0] * 8'd37) ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction

  task automatic set_rv(input bit s, input logic v);
    if (s) rv4 = v; else rv2 = v;
  endtask

  task automatic run(input bit s, input logic [31:0] a,
                     input logic rw, input logic [1:0] sz,
                     input logic u, input logic [31:0] wd,
                     input int dly, input bit pulse,
                     output logic [31:0] got);
    int bb, n, nb;
    bit swap, err;
    logic [31:0] a0, ba, d, ebe, ewd, erd, exp;
    bb = s ? 4 : 2;
    swap = !s;
    n = 1 << sz;
    err = (sz == 2'd3) || (s && (a % n) != 0);
    exp = '0;
    if (!err && !rw) begin
      for (int i = 0; i < n; i++) exp[8*i +: 8] = mbyte(a + 32'(i));
      if (!u && n < 4 && exp[8*n-1])
        exp = exp | ~((32'd1 << (8*n)) - 32'd1);
    end
    sel = s;
    @(negedge clk);
    chk("ready_before", c_rdy, 1);
    raddr = a; rrw = rw; rsize = sz; runs = u; rwd = wd;
    set_rv(s, 1'b1);
    @(negedge clk);
    set_rv(s, 1'b0);
    if (err) begin
      chk("err_valid", c_vld, 1);
      chk("err_flag", c_err, 1);
      chk("err_mreq", c_mreq, 0);
      chk("err_rdata", c_rd, 0);
    end else begin
      a0 = a & ~(32'(bb) - 32'd1);
      nb = (int'(a - a0) + n + bb - 1) / bb;
      for (int b = 0; b < nb; b++) begin
        ba = a0 + 32'(b * bb);
        ebe = '0; ewd = '0; erd = '0;
        for (int i = 0; i < n; i++) begin
          d = a + 32'(i) - ba;
          if (d < 32'(bb)) begin
            int pos;
            pos = swap ? bb - 1 - int'(d) : int'(d);
            ebe[pos] = 1'b1;
            ewd[8*pos +: 8] = wd[8*i +: 8];
          end
        end
        for (int pos = 0; pos < bb; pos++)
          erd[8*pos +: 8] = mbyte(ba + 32'(swap ? bb - 1 - pos : pos));
        for (int w = 0; w <= dly; w++) begin
          if (w > 0) @(negedge clk);
          chk("mem_req", c_mreq, 1);
          chk("mem_addr", c_ma, ba);
          chk("mem_be", c_be, ebe);
          chk("mem_wdata", c_wd, ewd);
          chk("mem_rw", c_mrw, {31'b0, rw});
          chk("no_rsp_in_issue", c_vld, 0);
          if (pulse && b == 0 && w == 0 && dly > 0) begin
            set_rv(s, 1'b1); raddr = ~a;
          end else begin
            set_rv(s, 1'b0); raddr = a;
          end
          mack = (w == dly);
          mrd = erd;
        end
        @(negedge clk);
        mack = 1'b0;
        set_rv(s, 1'b0);
        raddr = a;
      end
      chk("rsp_valid", c_vld, 1);
      chk("rsp_err", c_err, 0);
      chk("rsp_mreq", c_mreq, 0);
      chk("rsp_rdata", c_rd, exp);
    end
    got = c_rd;
    @(negedge clk);
    chk("rsp_one_cycle", c_vld, 0);
    chk("ready_after", c_rdy, 1);
    chk("rdata_hold", c_rd, exp);
  endtask

  logic [31:0] got;

  initial begin
    reset = 1'b1;
    rv2 = 0; rv4 = 0; raddr = '0; rrw = 0; rsize = '0;
    runs = 0; rwd = '0; mack = 0; mrd = '0; sel = 0;

    #12;
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      #1;
      chk("rst_ready", c_rdy, 0);
      chk("rst_mreq", c_mreq, 0);
      chk("rst_valid", c_vld, 0);
      chk("rst_rdata", c_rd, 0);
      chk("rst_be", c_be, 0);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    sel = 0; #1 chk("first_ready2", c_rdy, 1);
    sel = 1; #1 chk("first_ready4", c_rdy, 1);

    run(0, 32'h0001_0001, 1'b1, 2'd2, 1'b0, 32'h1122_3344, 0, 0, got);
    chk("store_rdata", got, 0);

    mem[32'h20] = 8'h80; mem[32'h21] = 8'hFF;
    run(0, 32'h20, 1'b0, 2'd0, 1'b0, '0, 0, 0, got);
    chk("lb_signed", got, 32'hFFFF_FF80);
    run(0, 32'h20, 1'b0, 2'd0, 1'b1, '0, 1, 0, got);
    chk("lb_unsigned", got, 32'h0000_0080);

    mem[32'h2] = 8'hAA; mem[32'h3] = 8'h12;
    mem[32'h4] = 8'h34; mem[32'h5] = 8'hBB;
    run(0, 32'h3, 1'b0, 2'd1, 1'b0, '0, 0, 0, got);
    chk("lh_split", got, 32'h0000_3412);

    run(1, 32'h102, 1'b0, 2'd2, 1'b0, '0, 0, 0, got);
    run(1, 32'h100, 1'b0, 2'd3, 1'b0, '0, 0, 0, got);
    run(0, 32'h100, 1'b1, 2'd3, 1'b0, 32'hDEAD_BEEF, 0, 0, got);

    run(1, 32'h40, 1'b0, 2'd2, 1'b0, '0, 3, 1, got);
    run(0, 32'hFFFF_FFFF, 1'b0, 2'd2, 1'b0, '0, 1, 1, got);
    run(1, 32'hFFFF_FFFE, 1'b1, 2'd1, 1'b0, 32'h0000_A55A, 0, 0, got);

    sel = 0;
    @(negedge clk);
    raddr = 32'h1; rrw = 0; rsize = 2'd1; runs = 0; rv2 = 1;
    @(negedge clk);
    rv2 = 0;
    chk("rst_t_beat0", c_ma, 32'h0);
    mack = 1; mrd = 32'h0000_1234;
    @(negedge clk);
    mack = 0;
    chk("rst_t_beat1_req", c_mreq, 1);
    chk("rst_t_beat1_addr", c_ma, 32'h2);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_mreq", c_mreq, 0);
    chk("rst_mid_valid", c_vld, 0);
    chk("rst_mid_ready", c_rdy, 0);
    chk("rst_mid_rdata", c_rd, 0);
    @(negedge clk);
    chk("rst_hold_valid", c_vld, 0);
    reset = 1'b0;
    #1 chk("rst_rel_ready", c_rdy, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_no_rsp", c_vld, 0);
      chk("rst_no_mreq", c_mreq, 0);
    end
    run(0, 32'hFFFF_FFFF, 1'b0, 2'd0, 1'b0, '0, 0, 0, got);

    for (int t = 0; t < 80; t++) begin
      bit s;
      logic [31:0] a;
      logic [1:0] sz;
      s = ($urandom_range(0, 1) == 1);
      a = $urandom;
      if ($urandom_range(0, 3) == 0)
        a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      run(s, a, 1'($urandom_range(0, 1)), sz,
          1'($urandom_range(0, 1)), $urandom,
          $urandom_range(0, 2), ($urandom_range(0, 1) == 1), got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
